// File: rtl/stopwatch_core_pkg.sv
// Shared types and game-level sizing for the stopwatch core.
package stopwatch_core_pkg;

    localparam int unsigned BCD_W            = 4;
    localparam int unsigned STOPWATCH_DIGITS = 4;
    localparam int unsigned WIN_DIGITS       = 2;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_ZERO = 4'd0;
    localparam bcd_t BCD_MAX  = 4'd9;

endpackage

// File: rtl/stopwatch_core_if.sv
// Control/status bundle between the game FSM (master) and the stopwatch core (slave).
interface stopwatch_core_if #(
    parameter int unsigned DIGITS = stopwatch_core_pkg::STOPWATCH_DIGITS
);
    logic                clr;
    logic                pause;
    logic [DIGITS*4-1:0] digits;
    logic                tick;
    logic                win;
    logic                ovf;

    modport master (output clr, output pause, input digits, input tick, input win, input ovf);
    modport slave  (input clr, input pause, output digits, output tick, output win, output ovf);
endinterface

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD digit register; increments when enabled with carry in, wraps 9 -> 0 with carry out.
module stopwatch_core_bcd_digit
    import stopwatch_core_pkg::*;
(
    input  logic clk_i,
    input  logic res_ni,
    input  logic clr_i,
    input  logic en_i,
    input  logic carry_i,
    output bcd_t digit_o,
    output logic carry_o
);

    bcd_t digit_q;
    logic at_max;

    assign at_max  = (digit_q == BCD_MAX);
    assign carry_o = carry_i & at_max;
    assign digit_o = digit_q;

    always_ff @(posedge clk_i or negedge res_ni) begin
        if (!res_ni) begin
            digit_q <= BCD_ZERO;
        end else if (clr_i) begin
            digit_q <= BCD_ZERO;
        end else if (en_i && carry_i) begin
            digit_q <= at_max ? BCD_ZERO : digit_q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Prescaled BCD stopwatch: clear/pause control, tick pulse, sticky wrap flag and win compare.
module stopwatch_core #(
    parameter int unsigned TICK_DIV   = 500_000,
    parameter int unsigned DIGITS     = stopwatch_core_pkg::STOPWATCH_DIGITS,
    parameter int unsigned WIN_DIGITS = stopwatch_core_pkg::WIN_DIGITS
) (
    input  logic             clk_i,
    input  logic             res_ni,
    stopwatch_core_if.slave  sw
);
    import stopwatch_core_pkg::*;

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] presc_q;
    logic             tick_q;
    logic             ovf_q;
    logic             run;
    logic             step;
    logic [DIGITS:0]  carry;
    logic [DIGITS-1:0] is_zero;
    bcd_t             digit_q [DIGITS];

    assign run  = !sw.clr && !sw.pause;
    assign step = run && (presc_q == PRE_LAST);

    // Prescaler phase survives pause; only clear or reset rewinds it.
    always_ff @(posedge clk_i or negedge res_ni) begin
        if (!res_ni) begin
            presc_q <= '0;
        end else if (sw.clr) begin
            presc_q <= '0;
        end else if (step) begin
            presc_q <= '0;
        end else if (run) begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge res_ni) begin
        if (!res_ni) begin
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            tick_q <= step;
            if (sw.clr) begin
                ovf_q <= 1'b0;
            end else if (step && carry[DIGITS]) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        stopwatch_core_bcd_digit u_digit (
            .clk_i   (clk_i),
            .res_ni  (res_ni),
            .clr_i   (sw.clr),
            .en_i    (step),
            .carry_i (carry[g]),
            .digit_o (digit_q[g]),
            .carry_o (carry[g+1])
        );
        assign is_zero[g]          = (digit_q[g] == BCD_ZERO);
        assign sw.digits[g*4 +: 4] = digit_q[g];
    end

    // Win depends only on digit registers: low digits zero, something above them non-zero.
    assign sw.win  = (&is_zero[WIN_DIGITS-1:0]) && !(&is_zero[DIGITS-1:WIN_DIGITS]);
    assign sw.tick = tick_q;
    assign sw.ovf  = ovf_q;

endmodule
